// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back unit.
package wb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_e;

  // Occupancy/pending-counter width able to hold the value DEPTH itself.
  function automatic int unsigned wb_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular write-back queue: dual enqueue (mem slot first, alu second), single pop.
// With WB_BYPASS_EN defined it also exports an age-ordered view of live entries.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push_mem,
  input  wb_entry_t                   i_mem_ent,
  input  logic                        i_push_alu,
  input  wb_entry_t                   i_alu_ent,
  input  logic                        i_pop,
  output logic [wb_cnt_w(DEPTH)-1:0]  o_count,
  output wb_entry_t                   o_head
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0]            o_age_valid,
  output wb_entry_t [DEPTH-1:0]       o_age_ent
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = wb_cnt_w(DEPTH);

  wb_entry_t       r_slot [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_alu_ptr;
  logic [PW-1:0]   w_wr_adv;
  logic [CW-1:0]   w_count_nxt;

  // The alu entry lands one slot behind the mem entry when both push.
  always_comb begin
    w_alu_ptr   = r_wr_ptr + PW'(i_push_mem);
    w_wr_adv    = PW'(i_push_mem) + PW'(i_push_alu);
    w_count_nxt = r_count + CW'(i_push_mem) + CW'(i_push_alu) - CW'(i_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_wr_adv;
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= w_count_nxt;
    end
  end

  // Payload storage needs no reset: only slots covered by r_count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push_mem) begin
      r_slot[r_wr_ptr] <= i_mem_ent;
    end
    if (i_push_alu) begin
      r_slot[w_alu_ptr] <= i_alu_ent;
    end
  end

  always_comb begin
    o_count = r_count;
    o_head  = r_slot[r_rd_ptr];
  end

`ifdef WB_BYPASS_EN
  // Slot i of the view is the i-th oldest entry; higher index means younger.
  always_comb begin
    o_age_valid = '0;
    o_age_ent   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_age_valid[i] = (CW'(i) < r_count);
      o_age_ent[i]   = r_slot[r_rd_ptr + PW'(i)];
    end
  end
`endif

endmodule

// File: rtl/wb_writeback_unit.sv
// Register-file write-back producer: queues ALU/load results, retires one per cycle,
// and tracks pending writes for RAW hazard queries. WB_BYPASS_EN enables forwarding.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [AW-1:0]               alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [AW-1:0]               mem_rd,
  input  logic [XLEN-1:0]             mem_data,
  output logic [AW-1:0]               rd_addr,
  output logic [XLEN-1:0]             rd_data,
  output logic                        reg_write,
  input  logic [AW-1:0]               q_rs1_addr,
  input  logic [AW-1:0]               q_rs2_addr,
  output logic                        q_rs1_busy,
  output logic                        q_rs2_busy,
  output logic [XLEN-1:0]             q_rs1_fwd,
  output logic [XLEN-1:0]             q_rs2_fwd,
  output logic [wb_cnt_w(DEPTH)-1:0]  wb_count
);

  localparam int unsigned CW = wb_cnt_w(DEPTH);

  logic [CW-1:0]   w_count;
  wb_entry_t       w_head;
  wb_entry_t       w_mem_ent;
  wb_entry_t       w_alu_ent;
  logic            w_empty;
  logic            w_pop;
  logic [CW-1:0]   w_free;
  logic            w_push_mem;
  logic            w_push_alu;

  logic [CW-1:0]   r_pend     [NREGS];
  logic [CW-1:0]   w_pend_nxt [NREGS];

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0]      w_age_valid;
  wb_entry_t [DEPTH-1:0] w_age_ent;
`endif

  // Free slots include the entry popped this cycle; mem wins the last slot.
  always_comb begin
    w_empty    = (w_count == '0);
    w_pop      = !w_empty;
    w_free     = CW'(DEPTH) - w_count + CW'(!w_empty);
    mem_ready  = (w_free >= CW'(1));
    alu_ready  = (w_free >= CW'(2)) | ((w_free >= CW'(1)) & !mem_valid);
    w_push_mem = mem_valid & mem_ready & (mem_rd != '0);
    w_push_alu = alu_valid & alu_ready & (alu_rd != '0);
    w_mem_ent  = '{rd: mem_rd, data: mem_data};
    w_alu_ent  = '{rd: alu_rd, data: alu_data};
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push_mem  (w_push_mem),
    .i_mem_ent   (w_mem_ent),
    .i_push_alu  (w_push_alu),
    .i_alu_ent   (w_alu_ent),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
`ifdef WB_BYPASS_EN
    ,
    .o_age_valid (w_age_valid),
    .o_age_ent   (w_age_ent)
`endif
  );

  // A write in the reset cycle is suppressed so discarded entries never reach the file.
  always_comb begin
    reg_write = w_pop & !rst;
    rd_addr   = w_head.rd;
    rd_data   = w_head.data;
    wb_count  = w_count;
  end

  // Pending-write counters; same-cycle enqueue and pop on one register cancel.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_pend_nxt[r] = r_pend[r]
                    + CW'(w_push_mem && (mem_rd == AW'(r)))
                    + CW'(w_push_alu && (alu_rd == AW'(r)))
                    - CW'(w_pop && (w_head.rd == AW'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_pend[r] <= w_pend_nxt[r];
      end
    end
  end

  always_comb begin
    q_rs1_busy = (r_pend[q_rs1_addr] != '0);
    q_rs2_busy = (r_pend[q_rs2_addr] != '0);
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    q_rs1_fwd = '0;
    q_rs2_fwd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_age_valid[i] && (w_age_ent[i].rd == q_rs1_addr)) begin
        q_rs1_fwd = w_age_ent[i].data;
      end
      if (w_age_valid[i] && (w_age_ent[i].rd == q_rs2_addr)) begin
        q_rs2_fwd = w_age_ent[i].data;
      end
    end
  end
`else
  always_comb begin
    q_rs1_fwd = '0;
    q_rs2_fwd = '0;
  end
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours WB_BYPASS_EN for forwarding expectations.
module tb_wb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0]   alu_rd, mem_rd, rd_addr, q_rs1_addr, q_rs2_addr;
  logic [XLEN-1:0] alu_data, mem_data, rd_data, q_rs1_fwd, q_rs2_fwd;
  logic            reg_write, q_rs1_busy, q_rs2_busy;
  logic [CW-1:0]   wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t       mq[$];
  logic [XLEN-1:0] rf_model [32];
  logic [XLEN-1:0] rf_dut   [32];
  bit              wr_seen  [32];

  wb_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .reg_write  (reg_write),
    .q_rs1_addr (q_rs1_addr),
    .q_rs2_addr (q_rs2_addr),
    .q_rs1_busy (q_rs1_busy),
    .q_rs2_busy (q_rs2_busy),
    .q_rs1_fwd  (q_rs1_fwd),
    .q_rs2_fwd  (q_rs2_fwd),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  // Register file as seen through the DUT's write port.
  always @(posedge clk) begin
    if (reg_write) begin
      rf_dut[rd_addr]  <= rd_data;
      wr_seen[rd_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [AW-1:0] a);
    bit b;
    b = 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) b = 1'b1;
    return b;
  endfunction

  function automatic logic [XLEN-1:0] exp_fwd(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    foreach (mq[i]) if (mq[i].rd == a) v = mq[i].data;
`ifndef WB_BYPASS_EN
    v = '0;
`endif
    return v;
  endfunction

  // One clock cycle: drive, check against the model mid-cycle, advance the model.
  task automatic cycle(input bit r,
                       input bit mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                       input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    int        n;
    int        fr;
    bit        er_m, er_a;
    wb_entry_t e;
    rst = r; mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad; q_rs1_addr = a1; q_rs2_addr = a2;
    @(negedge clk);
    n    = mq.size();
    fr   = DEPTH - n + ((n != 0) ? 1 : 0);
    er_m = (fr >= 1);
    er_a = (fr >= 2) || ((fr >= 1) && !mv);
    chk("wb_count", XLEN'(wb_count), XLEN'(n));
    chk("reg_write", XLEN'(reg_write), XLEN'((n != 0) && !r));
    if (n != 0) begin
      chk("rd_addr", XLEN'(rd_addr), XLEN'(mq[0].rd));
      chk("rd_data", rd_data, mq[0].data);
    end
    chk("mem_ready", XLEN'(mem_ready), XLEN'(er_m));
    chk("alu_ready", XLEN'(alu_ready), XLEN'(er_a));
    chk("rs1_busy", XLEN'(q_rs1_busy), XLEN'(exp_busy(a1)));
    chk("rs2_busy", XLEN'(q_rs2_busy), XLEN'(exp_busy(a2)));
    chk("rs1_fwd", q_rs1_fwd, exp_fwd(a1));
    chk("rs2_fwd", q_rs2_fwd, exp_fwd(a2));
    if (r) begin
      mq.delete();
    end else begin
      if (n != 0) begin
        rf_model[mq[0].rd] = mq[0].data;
        void'(mq.pop_front());
      end
      if (mv && er_m && (mrd != '0)) begin
        e.rd = mrd; e.data = md; mq.push_back(e);
      end
      if (av && er_a && (ard != '0)) begin
        e.rd = ard; e.data = ad; mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a1, a2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0; rf_dut[i] = '0; wr_seen[i] = 1'b0;
    end
    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
    q_rs1_addr = 5'd5; q_rs2_addr = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wb_count", XLEN'(wb_count), '0);
    chk("rst_reg_write", XLEN'(reg_write), '0);
    chk("rst_busy1", XLEN'(q_rs1_busy), '0);
    chk("rst_fwd1", q_rs1_fwd, '0);

    // Single load result, one-cycle latency.
    cycle(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, '0, '0, 5'd5, 5'd0);
    chk("t1_reg_write", XLEN'(reg_write), 64'd1);
    chk("t1_rd_addr", XLEN'(rd_addr), 64'd5);
    chk("t1_rd_data", rd_data, 64'hAA);
    idle(5'd5, 5'd0);
    chk("t1_reg_write_off", XLEN'(reg_write), 64'd0);

    // Both channels to rd=3: mem first, alu second.
    cycle(1'b0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22, 5'd3, 5'd0);
    chk("t2_busy_a", XLEN'(q_rs1_busy), 64'd1);
    chk("t2_data_a", rd_data, 64'h11);
    idle(5'd3, 5'd0);
    chk("t2_busy_b", XLEN'(q_rs1_busy), 64'd1);
    chk("t2_data_b", rd_data, 64'h22);
    idle(5'd3, 5'd0);
    chk("t2_busy_c", XLEN'(q_rs1_busy), 64'd0);

    // Saturate with both channels valid every cycle.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, AW'($urandom_range(1, 31)), {$urandom(), $urandom()},
            1'b1, AW'($urandom_range(1, 31)), {$urandom(), $urandom()}, 5'd1, 5'd2);
    end
    chk("t3_full", XLEN'(wb_count), 64'd4);
    chk("t3_alu_blocked", XLEN'(alu_ready), 64'd0);
    chk("t3_mem_ok", XLEN'(mem_ready), 64'd1);
    for (int i = 0; i < 5; i++) idle(5'd1, 5'd2);

    // rd=0 completes the handshake but enqueues nothing.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 64'hFF, 5'd0, 5'd0);
    chk("t4_wb_count", XLEN'(wb_count), 64'd0);
    chk("t4_reg_write", XLEN'(reg_write), 64'd0);

    // Reset mid-operation discards queued writes.
    for (int i = 0; i < 32; i++) wr_seen[i] = 1'b0;
    cycle(1'b0, 1'b1, 5'd7, 64'h7, 1'b1, 5'd8, 64'h8, 5'd8, 5'd9);
    cycle(1'b0, 1'b1, 5'd9, 64'h9, 1'b0, '0, '0, 5'd8, 5'd9);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd8, 5'd9);
    rst = 1'b0;
    chk("t5_reg_write", XLEN'(reg_write), 64'd0);
    chk("t5_wb_count", XLEN'(wb_count), 64'd0);
    chk("t5_busy8", XLEN'(q_rs1_busy), 64'd0);
    chk("t5_busy9", XLEN'(q_rs2_busy), 64'd0);
    q_rs1_addr = 5'd7; #1;
    chk("t5_busy7", XLEN'(q_rs1_busy), 64'd0);
    chk("t5_r8_unwritten", XLEN'(wr_seen[8]), 64'd0);
    chk("t5_r9_unwritten", XLEN'(wr_seen[9]), 64'd0);
    chk("t5_r7_written", XLEN'(wr_seen[7]), 64'd1);

    // Forwarding returns the youngest queued value.
    cycle(1'b0, 1'b1, 5'd4, 64'h1, 1'b1, 5'd4, 64'h2, 5'd4, 5'd0);
    chk("t6_fwd_both", q_rs1_fwd, BYP ? 64'h2 : 64'h0);
    idle(5'd4, 5'd0);
    chk("t6_fwd_one", q_rs1_fwd, BYP ? 64'h2 : 64'h0);
    idle(5'd4, 5'd0);
    chk("t6_fwd_none", q_rs1_fwd, 64'h0);

    // Randomized traffic with small rd range to force collisions.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), {$urandom(), $urandom()},
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), {$urandom(), $urandom()},
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) idle(5'd0, 5'd0);

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rf[%0d]", i), rf_dut[i], rf_model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
